mac_operand_abs_stage: RTL and testbench

Front-end sign-split stage of the configurable MAC. It takes packed signed or unsigned A/B operands and emits their unsigned magnitudes plus per-lane "product is negative" flags. The magnitudes feed the unsigned multiplier array, and the flags travel alongside to the accumulator negator, which re-applies the sign after multiplication. The stage is a 2-deep valid/ready pipeline that carries `cfg` aligned with the data.

---
 rtl/mac_operand_abs_stage.sv | 216 +++++++++++++++++++++
 tb/tb_mac_operand_abs_stage.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/mac_operand_abs_stage.sv
// -----------------------------------------------------------------------------
// mac_operand_abs_stage
//
// Front-end sign-split stage of the configurable MAC. Converts packed signed or
// unsigned A/B operands into unsigned magnitudes for the multiplier array and
// produces per-lane "product is negative" flags for the accumulator negator.
// Two-deep valid/ready pipeline (S1 = operand register, S2 = result register);
// cfg travels with the data.
//
// Optional build macro:
//   MAC_ABS_SINGLE_STAGE_EN  removes S1; the sign-split logic works directly on
//                            A_in/B_in into S2 (latency 1, capacity 1).
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   en                   global enable; 0 freezes all state
//   in_valid / in_ready  input handshake (in_ready is combinational on out_ready)
//   cfg                  [3] signed, [2] mac/mul (pass-through),
//                        [1:0] 01 dual, 10 quad, otherwise single
//   A_in, B_in           packed operands, lane i = [i*W +: W]
//   out_valid/out_ready  output handshake
//   A_mag, B_mag         unsigned magnitudes
//   neg                  per-lane negative-product flag
//   cfg_out              cfg aligned with the output data
// -----------------------------------------------------------------------------
module mac_operand_abs_stage #(
  parameter int MAC_CONF_WIDTH = 4,
  parameter int MAC_MIN_WIDTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [MAC_CONF_WIDTH-1:0]    cfg,
  input  logic [4*MAC_MIN_WIDTH-1:0]   A_in,
  input  logic [4*MAC_MIN_WIDTH-1:0]   B_in,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [4*MAC_MIN_WIDTH-1:0]   A_mag,
  output logic [4*MAC_MIN_WIDTH-1:0]   B_mag,
  output logic [3:0]                   neg,
  output logic [MAC_CONF_WIDTH-1:0]    cfg_out
);

  localparam int W   = MAC_MIN_WIDTH;
  localparam int OPW = 4 * W;

  typedef enum logic [1:0] {
    MODE_SINGLE,
    MODE_DUAL,
    MODE_QUAD
  } mode_e;

  // ---------------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------------
  logic                      s2_valid;
  logic                      s2_adv;
  logic                      s2_load;
  logic                      in_fire;

  // Source of the sign-split logic (S1 register or raw inputs).
  logic [OPW-1:0]            src_a;
  logic [OPW-1:0]            src_b;
  logic [MAC_CONF_WIDTH-1:0] src_cfg;

  assign s2_adv    = ~s2_valid | (out_ready & en);
  assign in_fire   = in_valid & in_ready;
  assign out_valid = s2_valid & en;

`ifdef MAC_ABS_SINGLE_STAGE_EN
  assign src_a    = A_in;
  assign src_b    = B_in;
  assign src_cfg  = cfg;
  assign in_ready = en & s2_adv;
  assign s2_load  = in_fire;
`else
  logic                      s1_valid;
  logic [OPW-1:0]            s1_a;
  logic [OPW-1:0]            s1_b;
  logic [MAC_CONF_WIDTH-1:0] s1_cfg;

  assign in_ready = en & (~s1_valid | s2_adv);
  assign s2_load  = s1_valid & s2_adv;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values and the pipeline shifts without races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_cfg   <= '0;
    end else if (en) begin
      if (in_fire) begin
        s1_valid <= 1'b1;
        s1_a     <= A_in;
        s1_b     <= B_in;
        s1_cfg   <= cfg;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  assign src_a   = s1_a;
  assign src_b   = s1_b;
  assign src_cfg = s1_cfg;
`endif

  // ---------------------------------------------------------------------------
  // Lane grouping: which lane holds each lane's group sign, and where a
  // group's negation carry chain starts.
  // ---------------------------------------------------------------------------
  mode_e           mode;
  logic [3:0][1:0] top_lane;
  logic [3:0]      grp_start;

  // NOTE: every variable written in a combinational block gets a default
  // first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    mode      = MODE_SINGLE;
    top_lane  = '0;
    grp_start = '0;
    case (src_cfg[1:0])
      2'b01:   mode = MODE_DUAL;
      2'b10:   mode = MODE_QUAD;
      default: mode = MODE_SINGLE;
    endcase
    for (int i = 0; i < 4; i++) begin
      case (mode)
        MODE_DUAL: begin
          top_lane[i]  = 2'(i | 1);
          grp_start[i] = (i % 2 == 0);
        end
        MODE_QUAD: begin
          top_lane[i]  = 2'd3;
          grp_start[i] = (i == 0);
        end
        default: begin
          top_lane[i]  = 2'(i);
          grp_start[i] = 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Sign split. Negation is ~x + 1 done lane by lane; the +1 enters at each
  // group's bottom lane and the carry ripples upward inside the group. The
  // most-negative value wraps to itself, which read as unsigned is its
  // magnitude.
  // ---------------------------------------------------------------------------
  logic [3:0][W-1:0] a_lanes, b_lanes;
  logic [3:0][W-1:0] a_abs, b_abs;
  logic [3:0]        a_sign, b_sign;
  logic [3:0]        neg_c;
  logic [W:0]        a_sum, b_sum;
  logic              a_carry, b_carry;

  assign a_lanes = src_a;
  assign b_lanes = src_b;

  always_comb begin
    a_abs   = a_lanes;
    b_abs   = b_lanes;
    a_sign  = '0;
    b_sign  = '0;
    neg_c   = '0;
    a_sum   = '0;
    b_sum   = '0;
    a_carry = 1'b0;
    b_carry = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_sign[i] = a_lanes[top_lane[i]][W-1];
      b_sign[i] = b_lanes[top_lane[i]][W-1];
      a_sum     = {1'b0, ~a_lanes[i]} + {{W{1'b0}}, grp_start[i] | a_carry};
      b_sum     = {1'b0, ~b_lanes[i]} + {{W{1'b0}}, grp_start[i] | b_carry};
      a_carry   = a_sum[W];
      b_carry   = b_sum[W];
      if (src_cfg[3]) begin
        a_abs[i] = a_sign[i] ? a_sum[W-1:0] : a_lanes[i];
        b_abs[i] = b_sign[i] ? b_sum[W-1:0] : b_lanes[i];
        neg_c[i] = a_sign[i] ^ b_sign[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2 result register. Loads only when empty or being popped, so the outputs
  // hold while stalled.
  // ---------------------------------------------------------------------------
  // NOTE: the data registers are reset as well as the valid bit because the
  // outputs are defined to read 0 during reset, not just to be invalid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      A_mag    <= '0;
      B_mag    <= '0;
      neg      <= '0;
      cfg_out  <= '0;
    end else if (en) begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        A_mag    <= a_abs;
        B_mag    <= b_abs;
        neg      <= neg_c;
        cfg_out  <= src_cfg;
      end else if (s2_adv) begin
        s2_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mac_operand_abs_stage.sv
// -----------------------------------------------------------------------------
// tb_mac_operand_abs_stage
//
// Directed self-checking bench for mac_operand_abs_stage (default two-stage
// build): grouping/sign vectors with hand-computed results, backpressure,
// enable freeze and asynchronous reset mid-stream.
// -----------------------------------------------------------------------------
module tb_mac_operand_abs_stage;

  localparam int CW  = 4;
  localparam int W   = 8;
  localparam int OPW = 4 * W;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic           in_valid;
  logic           in_ready;
  logic [CW-1:0]  cfg;
  logic [OPW-1:0] A_in;
  logic [OPW-1:0] B_in;
  logic           out_valid;
  logic           out_ready;
  logic [OPW-1:0] A_mag;
  logic [OPW-1:0] B_mag;
  logic [3:0]     neg;
  logic [CW-1:0]  cfg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_operand_abs_stage #(
    .MAC_CONF_WIDTH (CW),
    .MAC_MIN_WIDTH  (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg       (cfg),
    .A_in      (A_in),
    .B_in      (B_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .A_mag     (A_mag),
    .B_mag     (B_mag),
    .neg       (neg),
    .cfg_out   (cfg_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [CW-1:0] c,
                       input logic [OPW-1:0] a, input logic [OPW-1:0] b);
    in_valid = v;
    cfg      = c;
    A_in     = a;
    B_in     = b;
  endtask

  task automatic check_out(input string tag, input logic [OPW-1:0] ea,
                           input logic [OPW-1:0] eb, input logic [3:0] en_flags,
                           input logic [CW-1:0] ec);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_a_mag"}, A_mag, ea);
    check({tag, "_b_mag"}, B_mag, eb);
    check({tag, "_neg"},   32'(neg), 32'(en_flags));
    check({tag, "_cfg"},   32'(cfg_out), 32'(ec));
  endtask

  // One beat through an empty pipeline with out_ready high: accepted at edge
  // N, still invisible after N, presented after N+1, gone after N+2.
  task automatic send_and_check(input string tag, input logic [CW-1:0] c,
                                input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                                input logic [OPW-1:0] ea, input logic [OPW-1:0] eb,
                                input logic [3:0] en_flags);
    drive(1'b1, c, a, b);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    check({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    check_out(tag, ea, eb, en_flags, c);
    tick();
    check({tag, "_drain"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, '0);

    // Reset state
    #12;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_a_mag",     A_mag,          32'd0);
    check("rst_b_mag",     B_mag,          32'd0);
    check("rst_neg",       32'(neg),       32'd0);
    check("rst_cfg_out",   32'(cfg_out),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Grouping / sign vectors
    send_and_check("single", 4'b1000, 32'h80FF05FB, 32'h01FFFB02,
                   32'h80010505, 32'h01010502, 4'b1011);
    send_and_check("dual",   4'b1001, 32'hFFFF8000, 32'hFFFF0002,
                   32'h00018000, 32'h00010002, 4'b0011);
    send_and_check("quad",   4'b1010, 32'hFFFFFFFE, 32'h00000003,
                   32'h00000002, 32'h00000003, 4'b1111);
    send_and_check("unsig",  4'b0010, 32'hFFFFFFFF, 32'h80000000,
                   32'hFFFFFFFF, 32'h80000000, 4'b0000);
    // Quad most-negative and zero carry ripple through all lanes
    send_and_check("quadmin", 4'b1110, 32'h80000000, 32'hFFFFFF00,
                   32'h80000000, 32'h00000100, 4'b0000);

    // Backpressure: beats 1, 2, 3 with out_ready low
    out_ready = 1'b0;
    drive(1'b1, 4'b0100, 32'hA1A1A1A1, 32'h11111111);
    check("bp_ready1", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 4'b0100, 32'hA2A2A2A2, 32'h22222222);
    check("bp_ready2", 32'(in_ready), 32'd1);
    tick();
    drive(1'b1, 4'b0100, 32'hA3A3A3A3, 32'h33333333);
    check("bp_full", 32'(in_ready), 32'd0);
    check_out("bp_hold0", 32'hA1A1A1A1, 32'h11111111, 4'b0000, 4'b0100);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("bp_full_stall", 32'(in_ready), 32'd0);
      check_out("bp_hold", 32'hA1A1A1A1, 32'h11111111, 4'b0000, 4'b0100);
    end
    out_ready = 1'b1;
    #1;
    check("bp_ready_comb", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, '0, '0, '0);
    check_out("bp_beat2", 32'hA2A2A2A2, 32'h22222222, 4'b0000, 4'b0100);
    tick();
    check_out("bp_beat3", 32'hA3A3A3A3, 32'h33333333, 4'b0000, 4'b0100);
    tick();
    check("bp_empty", 32'(out_valid), 32'd0);

    // Freeze with two beats in flight
    drive(1'b1, 4'b1000, 32'h000000FF, 32'h00000001);
    tick();
    drive(1'b1, 4'b1001, 32'h0000FFFE, 32'h00000005);
    tick();
    drive(1'b0, '0, '0, '0);
    en = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("frz_out_valid", 32'(out_valid), 32'd0);
      check("frz_in_ready",  32'(in_ready),  32'd0);
      tick();
    end
    en = 1'b1;
    #1;
    check_out("frz_beat4", 32'h00000001, 32'h00000001, 4'b0001, 4'b1000);
    tick();
    check_out("frz_beat5", 32'h00000002, 32'h00000005, 4'b0011, 4'b1001);
    tick();
    check("frz_empty", 32'(out_valid), 32'd0);

    // Reset mid-stream
    out_ready = 1'b0;
    drive(1'b1, 4'b1000, 32'h80FF05FB, 32'h01FFFB02);
    tick();
    drive(1'b1, 4'b0000, 32'h12345678, 32'h9ABCDEF0);
    tick();
    drive(1'b0, '0, '0, '0);
    check_out("pre_rst", 32'h80010505, 32'h01010502, 4'b1011, 4'b1000);
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_a_mag",     A_mag,          32'd0);
    check("mid_rst_b_mag",     B_mag,          32'd0);
    check("mid_rst_neg",       32'(neg),       32'd0);
    check("mid_rst_cfg_out",   32'(cfg_out),   32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    tick();
    check("post_rst_empty1", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_empty2", 32'(out_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
